// File: rtl/y_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : y_shift_unit
// Purpose  : Y register with bus loads and a multi-cycle, bit-serial shifter
//            (LSL/LSR/ASR, plus ROR when Y_SHIFT_ROTATE_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================

module y_shift_unit #(
    parameter int WIDTH    = 16,
    parameter int AMT_W    = 4,
    parameter int OFFSET_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] DATA,
    input  logic             Y_in,
    input  logic             Y_offset_in,
    input  logic             Y_out,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] shift_amount,
    output logic [WIDTH-1:0] REG_OUT_Y,
    output logic [WIDTH-1:0] Y_bus_out,
    output logic             busy,
    output logic             done,
    output logic             carry_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] c_LSL = 2'b00;
    localparam logic [1:0] c_LSR = 2'b01;
    localparam logic [1:0] c_ASR = 2'b10;
    localparam logic [1:0] c_ROR = 2'b11;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_y;
    logic             r_carry;
    logic [AMT_W-1:0] r_cnt;
    logic [1:0]       r_mode;

    logic             w_can_load;
    logic             w_start_ok;
    logic             w_mode_nop;
    logic             w_go_shift;
    logic [WIDTH-1:0] w_offset;
    logic [WIDTH-1:0] w_shift_y;
    logic             w_shift_c;

    assign w_can_load = (r_state == ST_IDLE) || (r_state == ST_DONE);
    // A load in the same IDLE cycle takes priority and swallows the start.
    assign w_start_ok = (r_state == ST_IDLE) && start && !(Y_in || Y_offset_in);

`ifdef Y_SHIFT_ROTATE_EN
    assign w_mode_nop = 1'b0;
`else
    assign w_mode_nop = (mode == c_ROR);
`endif

    assign w_go_shift = w_start_ok && (shift_amount != '0) && !w_mode_nop;
    assign w_offset   = WIDTH'($signed(DATA[OFFSET_W-1:0]));

    always_comb begin
        w_shift_y = r_y;
        w_shift_c = 1'b0;
        case (r_mode)
            c_LSL: begin
                w_shift_y = {r_y[WIDTH-2:0], 1'b0};
                w_shift_c = r_y[WIDTH-1];
            end
            c_LSR: begin
                w_shift_y = {1'b0, r_y[WIDTH-1:1]};
                w_shift_c = r_y[0];
            end
            c_ASR: begin
                w_shift_y = {r_y[WIDTH-1], r_y[WIDTH-1:1]};
                w_shift_c = r_y[0];
            end
`ifdef Y_SHIFT_ROTATE_EN
            c_ROR: begin
                w_shift_y = {r_y[0], r_y[WIDTH-1:1]};
                w_shift_c = r_y[0];
            end
`endif
            default: begin
                w_shift_y = r_y;
                w_shift_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = w_go_shift ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == AMT_W'(1)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_y     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_mode  <= c_LSL;
        end else begin
            if (w_can_load && Y_in) begin
                r_y <= DATA;
            end else if (w_can_load && Y_offset_in) begin
                r_y <= w_offset;
            end

            if (w_go_shift) begin
                r_mode <= mode;
                r_cnt  <= shift_amount;
            end else if (w_start_ok && w_mode_nop) begin
                r_carry <= 1'b0;
            end

            if (r_state == ST_SHIFT) begin
                r_y     <= w_shift_y;
                r_carry <= w_shift_c;
                r_cnt   <= r_cnt - AMT_W'(1);
            end
        end
    end

    assign REG_OUT_Y = r_y;
    assign Y_bus_out = Y_out ? r_y : '0;
    assign busy      = (r_state == ST_SHIFT);
    assign done      = (r_state == ST_DONE);
    assign carry_out = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_y_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_y_shift_unit
// Purpose  : Self-checking bench for y_shift_unit: vector table, reference
//            model for random ops, and directed multi-cycle corner cases.
// Revision : 1.0 - initial release
// ============================================================================

module tb_y_shift_unit;

`ifdef Y_SHIFT_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] DATA;
    logic        Y_in;
    logic        Y_offset_in;
    logic        Y_out;
    logic        start;
    logic [1:0]  mode;
    logic [3:0]  shift_amount;
    logic [15:0] REG_OUT_Y;
    logic [15:0] Y_bus_out;
    logic        busy;
    logic        done;
    logic        carry_out;

    y_shift_unit #(.WIDTH(16), .AMT_W(4), .OFFSET_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .DATA         (DATA),
        .Y_in         (Y_in),
        .Y_offset_in  (Y_offset_in),
        .Y_out        (Y_out),
        .start        (start),
        .mode         (mode),
        .shift_amount (shift_amount),
        .REG_OUT_Y    (REG_OUT_Y),
        .Y_bus_out    (Y_bus_out),
        .busy         (busy),
        .done         (done),
        .carry_out    (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          kind;      // 0 Y_in, 1 Y_offset_in, 2 both
        logic [1:0]  mode;
        logic [3:0]  amt;
        logic [15:0] exp_y;
        logic        exp_c;
        int          exp_busy;
    } vec_t;

    typedef struct {
        logic [15:0] y;
        logic        c;
        int          busy;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [15:0] model_y;
    logic        model_c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word-level reference: whole-amount shifts, carry is the last bit to leave.
    function automatic void ref_op(input logic [15:0] y, input logic [1:0] m, input int a,
                                   input logic pc, output logic [15:0] ny,
                                   output logic nc, output int nb);
        ny = y;
        nc = pc;
        nb = 0;
        if (m == 2'b11 && !ROT) begin
            nc = 1'b0;
            return;
        end
        if (a == 0) return;
        nb = a;
        case (m)
            2'b00: begin ny = y << a;                      nc = y[16-a]; end
            2'b01: begin ny = y >> a;                      nc = y[a-1];  end
            2'b10: begin ny = 16'($signed(y) >>> a);       nc = y[a-1];  end
            default: begin ny = (y >> a) | (y << (16-a));  nc = y[a-1];  end
        endcase
    endfunction

    task automatic load(input logic [15:0] d, input int kind, input logic [15:0] ey);
        @(negedge clk);
        DATA        = d;
        Y_in        = (kind != 1);
        Y_offset_in = (kind != 0);
        Y_out       = 1'b1;
        @(negedge clk);
        Y_in        = 1'b0;
        Y_offset_in = 1'b0;
        check("load_y", 32'(REG_OUT_Y), 32'(ey));
        check("bus_on", 32'(Y_bus_out), 32'(ey));
        model_y = ey;
    endtask

    task automatic do_op(input logic [1:0] m, input logic [3:0] a, input logic [15:0] ey,
                         input logic ec, input int eb, input bit inject);
        exp_t e;
        exp_t p;
        int   nb;
        bit   got;
        e.y = ey; e.c = ec; e.busy = eb;
        @(negedge clk);
        mode = m; shift_amount = a; start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        nb  = 0;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin got = 1'b1; break; end
            if (busy) nb++;
            if (inject && k == 0) begin
                start = 1'b1; mode = 2'b01; shift_amount = 4'd5;
                Y_in = 1'b1; DATA = 16'hFFFF;
            end else begin
                start = 1'b0; Y_in = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; Y_in = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        if (exp_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL scoreboard_empty: got no entry, expected one");
        end else begin
            p = exp_q.pop_front();
            check("op_y",     32'(REG_OUT_Y), 32'(p.y));
            check("op_carry", 32'(carry_out), 32'(p.c));
            check("op_busy",  32'(nb),        32'(p.busy));
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        model_y = ey;
        model_c = ec;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[8];
        logic [15:0] ey, d;
        logic        ec;
        int          eb, a, dn;
        logic [1:0]  m;

        tbl[0] = '{16'hABAA, 0, 2'b00, 4'd3,  16'h5D50, 1'b1, 3};
        tbl[1] = '{16'hABAA, 0, 2'b01, 4'd3,  16'h1575, 1'b0, 3};
        tbl[2] = '{16'hABAA, 0, 2'b10, 4'd3,  16'hF575, 1'b0, 3};
        tbl[3] = '{16'hABAA, 0, 2'b11, 4'd4,  ROT ? 16'hAABA : 16'hABAA, ROT, ROT ? 4 : 0};
        tbl[4] = '{16'h00F3, 1, 2'b10, 4'd1,  16'hFFF9, 1'b1, 1};
        tbl[5] = '{16'h8003, 0, 2'b00, 4'd15, 16'h8000, 1'b1, 15};
        tbl[6] = '{16'h8000, 0, 2'b10, 4'd15, 16'hFFFF, 1'b0, 15};
        tbl[7] = '{16'h5555, 0, 2'b01, 4'd15, 16'h0000, 1'b1, 15};

        reset = 1'b0; DATA = '0; Y_in = 1'b0; Y_offset_in = 1'b0; Y_out = 1'b1;
        start = 1'b0; mode = 2'b00; shift_amount = '0;
        model_y = '0; model_c = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_y",     32'(REG_OUT_Y), 32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        check("rst_done",  32'(done),      32'h0);
        check("rst_carry", 32'(carry_out), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            load(tbl[i].data, tbl[i].kind,
                 tbl[i].kind == 1 ? {{8{tbl[i].data[7]}}, tbl[i].data[7:0]} : tbl[i].data);
            do_op(tbl[i].mode, tbl[i].amt, tbl[i].exp_y, tbl[i].exp_c, tbl[i].exp_busy, 1'b0);
        end

        // Y_in beats Y_offset_in; bus is zero when not enabled
        load(16'h1234, 2, 16'h1234);
        load(16'h00F3, 1, 16'hFFF3);
        Y_out = 1'b0;
        #1 check("bus_off", 32'(Y_bus_out), 32'h0);
        Y_out = 1'b1;

        // amount 0: done next cycle, Y and carry untouched
        load(16'h1357, 0, 16'h1357);
        do_op(2'b00, 4'd0, 16'h1357, model_c, 0, 1'b0);

        // start and Y_in during SHIFT are ignored
        load(16'h0003, 0, 16'h0003);
        do_op(2'b00, 4'd2, 16'h000C, 1'b0, 2, 1'b1);

        // load and start in the same IDLE cycle: load wins, no operation
        @(negedge clk);
        DATA = 16'h4444; Y_in = 1'b1; start = 1'b1; mode = 2'b00; shift_amount = 4'd2;
        @(negedge clk);
        Y_in = 1'b0; start = 1'b0;
        check("ldstart_y",    32'(REG_OUT_Y), 32'h4444);
        check("ldstart_busy", 32'(busy),      32'h0);
        @(negedge clk);
        check("ldstart_done", 32'(done),      32'h0);

        // reset mid-shift aborts with no done pulse
        load(16'h0001, 0, 16'h0001);
        @(negedge clk);
        mode = 2'b00; shift_amount = 4'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0; Y_in = 1'b1; DATA = 16'hFFFF;
        @(negedge clk);
        Y_in = 1'b0;
        check("shift_ignores_load", 32'(REG_OUT_Y), 32'h0002);
        repeat (2) @(negedge clk);
        check("busy_before_rst", 32'(busy), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("abort_y",     32'(REG_OUT_Y), 32'h0);
        check("abort_busy",  32'(busy),      32'h0);
        check("abort_carry", 32'(carry_out), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", 32'(dn), 32'h0);
        model_y = '0; model_c = 1'b0;

        // random operations against the word-level reference
        for (int i = 0; i < 8; i++) begin
            d = 16'($urandom);
            m = 2'($urandom_range(0, 3));
            a = $urandom_range(0, 15);
            load(d, 0, d);
            ref_op(model_y, m, a, model_c, ey, ec, eb);
            do_op(m, 4'(a), ey, ec, eb, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
